// File: rtl/decode_stage.sv
// Purpose : registered RV32I/RV64I decode; splits fields, builds immediates/controls, flags illegal opcodes.
// Latency : one cycle from input accept to out_valid.
// Backpr. : in_ready = (!out_valid || out_ready) && !hazard && !flush; outputs hold while stalled downstream.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 discards held bundle and any pending stall
//   in_valid/in_ready     fetch-side handshake; in_instr/in_pc carry the instruction
//   out_valid/out_ready   execute-side handshake; out_* carry the decoded bundle
//   stall_count           saturating count of load-use bubbles inserted
module decode_stage #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [6:0]         out_opcode,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_rs1,
    output logic [4:0]         out_rs2,
    output logic [2:0]         out_funct3,
    output logic [6:0]         out_funct7,
    output logic [XLEN-1:0]    out_imm,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic               out_RegWrite,
    output logic               out_MemRead,
    output logic               out_MemWrite,
    output logic               out_MemtoReg,
    output logic               out_ALUSrc,
    output logic               out_Branch,
    output logic               out_Jump,
    output logic [1:0]         out_ALUOp,
    output logic               out_illegal,
    output logic [15:0]        stall_count
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;

    // ------------------------------------------------------------------
    // Field extraction and immediates (built 32 bits wide, then
    // sign-extended to XLEN so the same code serves RV32 and RV64).
    // ------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i32, w_imm_s32, w_imm_b32, w_imm_j32, w_imm_u32;

    assign w_opcode  = in_instr[6:0];
    assign w_rd      = in_instr[11:7];
    assign w_funct3  = in_instr[14:12];
    assign w_rs1     = in_instr[19:15];
    assign w_rs2     = in_instr[24:20];
    assign w_funct7  = in_instr[31:25];

    assign w_imm_i32 = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_j32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
    assign w_imm_u32 = {in_instr[31:12], 12'b0};

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic [XLEN-1:0]    w_imm;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_regwrite, w_memread, w_memwrite, w_memtoreg;
    logic               w_alusrc, w_branch, w_jump, w_illegal;
    logic [1:0]         w_aluop;
    logic               w_use_rs1, w_use_rs2;

    always_comb begin
        w_imm      = '0;
        w_shamt    = '0;
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_alusrc   = 1'b0;
        w_branch   = 1'b0;
        w_jump     = 1'b0;
        w_aluop    = 2'b00;
        w_illegal  = 1'b0;
        // rs1 is a real source for everything except lui/auipc/jal;
        // illegal opcodes are treated conservatively as reading rs1.
        w_use_rs1  = 1'b1;
        w_use_rs2  = 1'b0;
        unique case (w_opcode)
            OP_R: begin
                w_regwrite = 1'b1;
                w_aluop    = 2'b10;
                w_use_rs2  = 1'b1;
            end
            OP_I: begin
                w_regwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_aluop    = 2'b11;
                w_imm      = XLEN'($signed(w_imm_i32));
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101)
                    w_shamt = in_instr[20 +: SHAMT_W];
            end
            OP_LD: begin
                w_regwrite = 1'b1;
                w_memread  = 1'b1;
                w_memtoreg = 1'b1;
                w_alusrc   = 1'b1;
                w_imm      = XLEN'($signed(w_imm_i32));
            end
            OP_ST: begin
                w_memwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_imm      = XLEN'($signed(w_imm_s32));
                w_use_rs2  = 1'b1;
            end
            OP_BR: begin
                w_branch   = 1'b1;
                w_aluop    = 2'b01;
                w_imm      = XLEN'($signed(w_imm_b32));
                w_use_rs2  = 1'b1;
            end
            OP_JAL: begin
                w_regwrite = 1'b1;
                w_jump     = 1'b1;
                w_alusrc   = 1'b1;
                w_imm      = XLEN'($signed(w_imm_j32));
                w_use_rs1  = 1'b0;
            end
            OP_JALR: begin
                w_regwrite = 1'b1;
                w_jump     = 1'b1;
                w_alusrc   = 1'b1;
                w_imm      = XLEN'($signed(w_imm_i32));
            end
            OP_LUI, OP_AUI: begin
                w_regwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_imm      = XLEN'($signed(w_imm_u32));
                w_use_rs1  = 1'b0;
            end
            default: begin
                w_illegal  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline register and handshake
    // ------------------------------------------------------------------
    logic               r_vld;
    logic [XLEN-1:0]    r_pc;
    logic [6:0]         r_opcode;
    logic [4:0]         r_rd, r_rs1, r_rs2;
    logic [2:0]         r_funct3;
    logic [6:0]         r_funct7;
    logic [XLEN-1:0]    r_imm;
    logic [SHAMT_W-1:0] r_shamt;
    logic               r_regwrite, r_memread, r_memwrite, r_memtoreg;
    logic               r_alusrc, r_branch, r_jump, r_illegal;
    logic [1:0]         r_aluop;
    logic [15:0]        r_stall_cnt;

    logic w_hazard;
    logic w_in_ready;
    logic w_accept;

    // Load-use: the load held in the output register writes a register
    // the incoming instruction reads. x0 is never a real dependency.
    assign w_hazard = r_vld && r_memread && (r_rd != 5'd0) && in_valid &&
                      ((w_use_rs1 && (w_rs1 == r_rd)) ||
                       (w_use_rs2 && (w_rs2 == r_rd)));

    // rst_n gate keeps in_ready low while reset is held.
    assign w_in_ready = rst_n && (!r_vld || out_ready) && !w_hazard && !flush;
    assign w_accept   = in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld       <= 1'b0;
            r_pc        <= '0;
            r_opcode    <= '0;
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_funct3    <= '0;
            r_funct7    <= '0;
            r_imm       <= '0;
            r_shamt     <= '0;
            r_regwrite  <= 1'b0;
            r_memread   <= 1'b0;
            r_memwrite  <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_alusrc    <= 1'b0;
            r_branch    <= 1'b0;
            r_jump      <= 1'b0;
            r_aluop     <= 2'b00;
            r_illegal   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (flush) begin
                r_vld <= 1'b0;
            end else if (w_accept) begin
                r_vld      <= 1'b1;
                r_pc       <= in_pc;
                r_opcode   <= w_opcode;
                r_rd       <= w_rd;
                r_rs1      <= w_rs1;
                r_rs2      <= w_rs2;
                r_funct3   <= w_funct3;
                r_funct7   <= w_funct7;
                r_imm      <= w_imm;
                r_shamt    <= w_shamt;
                r_regwrite <= w_regwrite;
                r_memread  <= w_memread;
                r_memwrite <= w_memwrite;
                r_memtoreg <= w_memtoreg;
                r_alusrc   <= w_alusrc;
                r_branch   <= w_branch;
                r_jump     <= w_jump;
                r_aluop    <= w_aluop;
                r_illegal  <= w_illegal;
            end else if (out_ready) begin
                // Bundle left with nothing to replace it: bubble.
                r_vld <= 1'b0;
            end

            // A bubble is only inserted when the load actually leaves;
            // a flush in the same cycle cancels it.
            if (w_hazard && out_ready && !flush && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = r_vld;
    assign out_pc       = r_pc;
    assign out_opcode   = r_opcode;
    assign out_rd       = r_rd;
    assign out_rs1      = r_rs1;
    assign out_rs2      = r_rs2;
    assign out_funct3   = r_funct3;
    assign out_funct7   = r_funct7;
    assign out_imm      = r_imm;
    assign out_shamt    = r_shamt;
    assign out_RegWrite = r_regwrite;
    assign out_MemRead  = r_memread;
    assign out_MemWrite = r_memwrite;
    assign out_MemtoReg = r_memtoreg;
    assign out_ALUSrc   = r_alusrc;
    assign out_Branch   = r_branch;
    assign out_Jump     = r_jump;
    assign out_ALUOp    = r_aluop;
    assign out_illegal  = r_illegal;
    assign stall_count  = r_stall_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Purpose : directed checks of decode_stage (RV32 instance plus an RV64 instance for shamt).
// Latency : expects decoded bundle one cycle after accept.
// Backpr. : exercises out_ready stalls, load-use bubbles and flush.
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RV32 instance ----------------
    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [31:0] in_instr = '0, in_pc = '0, out_pc, out_imm;
    logic [6:0]  out_opcode, out_funct7;
    logic [4:0]  out_rd, out_rs1, out_rs2, out_shamt;
    logic [2:0]  out_funct3;
    logic        out_RegWrite, out_MemRead, out_MemWrite, out_MemtoReg;
    logic        out_ALUSrc, out_Branch, out_Jump, out_illegal;
    logic [1:0]  out_ALUOp;
    logic [15:0] stall_count;

    decode_stage #(.XLEN(32), .SHAMT_W(5)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_shamt(out_shamt), .out_RegWrite(out_RegWrite), .out_MemRead(out_MemRead),
        .out_MemWrite(out_MemWrite), .out_MemtoReg(out_MemtoReg), .out_ALUSrc(out_ALUSrc),
        .out_Branch(out_Branch), .out_Jump(out_Jump), .out_ALUOp(out_ALUOp),
        .out_illegal(out_illegal), .stall_count(stall_count)
    );

    // ---------------- RV64 instance ----------------
    logic        in_valid64 = 1'b0;
    logic        in_ready64, out_valid64;
    logic [31:0] in_instr64 = '0;
    logic [63:0] in_pc64 = '0, out_pc64, out_imm64;
    logic [6:0]  out_opcode64, out_funct7_64;
    logic [4:0]  out_rd64, out_rs1_64, out_rs2_64;
    logic [5:0]  out_shamt64;
    logic [2:0]  out_funct3_64;
    logic        rw64, mr64, mw64, m2r64, as64, br64, j64, ill64;
    logic [1:0]  aop64;
    logic [15:0] stall_count64;

    decode_stage #(.XLEN(64), .SHAMT_W(6)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_pc(in_pc64),
        .out_valid(out_valid64), .out_ready(1'b1), .out_pc(out_pc64),
        .out_opcode(out_opcode64), .out_rd(out_rd64), .out_rs1(out_rs1_64), .out_rs2(out_rs2_64),
        .out_funct3(out_funct3_64), .out_funct7(out_funct7_64), .out_imm(out_imm64),
        .out_shamt(out_shamt64), .out_RegWrite(rw64), .out_MemRead(mr64),
        .out_MemWrite(mw64), .out_MemtoReg(m2r64), .out_ALUSrc(as64),
        .out_Branch(br64), .out_Jump(j64), .out_ALUOp(aop64),
        .out_illegal(ill64), .stall_count(stall_count64)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr);
        in_valid = v;
        in_instr = instr;
        #1;
    endtask

    int xfers;

    initial begin
        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_illegal",   64'(out_illegal), 64'd0);
        chk("rst_stall_cnt", 64'(stall_count), 64'd0);
        chk("rst_imm",       64'(out_imm), 64'd0);
        chk("rst_in_ready",  64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // ---------------- addi x1,x0,5 ----------------
        in_pc = 32'h100;
        drive(1'b1, 32'h00500093);
        tick();
        drive(1'b0, 32'h0);
        chk("addi_valid",  64'(out_valid), 64'd1);
        chk("addi_rd",     64'(out_rd), 64'd1);
        chk("addi_imm",    64'(out_imm), 64'd5);
        chk("addi_rw",     64'(out_RegWrite), 64'd1);
        chk("addi_alusrc", 64'(out_ALUSrc), 64'd1);
        chk("addi_aluop",  64'(out_ALUOp), 64'd3);
        chk("addi_memrd",  64'(out_MemRead), 64'd0);
        chk("addi_pc",     64'(out_pc), 64'h100);
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);

        // ---------------- beq x0,x0,-4 ----------------
        drive(1'b1, 32'hFE000EE3);
        tick();
        drive(1'b0, 32'h0);
        chk("beq_imm",    64'(out_imm), 64'hFFFFFFFC);
        chk("beq_branch", 64'(out_Branch), 64'd1);
        chk("beq_aluop",  64'(out_ALUOp), 64'd1);
        chk("beq_rw",     64'(out_RegWrite), 64'd0);
        tick();

        // ---------------- load-use: lw x2,0(x1); add x3,x2,x1 ----------------
        drive(1'b1, 32'h0000A103);
        tick();
        drive(1'b1, 32'h001101B3);
        chk("lw_memread",    64'(out_MemRead), 64'd1);
        chk("lw_memtoreg",   64'(out_MemtoReg), 64'd1);
        chk("lw_rd",         64'(out_rd), 64'd2);
        chk("hz_in_ready",   64'(in_ready), 64'd0);
        tick();
        chk("hz_bubble",     64'(out_valid), 64'd0);
        chk("hz_stall_cnt",  64'(stall_count), 64'd1);
        chk("hz_ready_back", 64'(in_ready), 64'd1);
        tick();
        drive(1'b0, 32'h0);
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_rd",    64'(out_rd), 64'd3);
        chk("add_rs1",   64'(out_rs1), 64'd2);
        chk("add_rs2",   64'(out_rs2), 64'd1);
        chk("add_aluop", 64'(out_ALUOp), 64'd2);
        tick();

        // ---------------- downstream backpressure ----------------
        out_ready = 1'b0;
        drive(1'b1, 32'h00500093);
        tick();
        drive(1'b1, 32'hFE000EE3);
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid",    64'(out_valid), 64'd1);
            chk("hold_imm",      64'(out_imm), 64'd5);
            chk("hold_rd",       64'(out_rd), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        drive(1'b0, 32'h0);
        out_ready = 1'b1;
        #1;
        xfers = 0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid && out_ready) xfers++;
            tick();
        end
        chk("hold_xfers", 64'(xfers), 64'd1);

        // ---------------- illegal and lui ----------------
        drive(1'b1, 32'h00000000);
        tick();
        drive(1'b1, 32'h12345037);
        chk("ill_flag",  64'(out_illegal), 64'd1);
        chk("ill_valid", 64'(out_valid), 64'd1);
        chk("ill_ctrl",  64'({out_RegWrite, out_MemRead, out_MemWrite, out_MemtoReg,
                              out_ALUSrc, out_Branch, out_Jump, out_ALUOp}), 64'd0);
        tick();
        drive(1'b0, 32'h0);
        chk("lui_imm",     64'(out_imm), 64'h12345000);
        chk("lui_illegal", 64'(out_illegal), 64'd0);
        chk("lui_rw",      64'(out_RegWrite), 64'd1);
        tick();

        // ---------------- rd = x0 never stalls: lw x0,0(x1); addi x1,x0,5 ----------------
        drive(1'b1, 32'h0000A003);
        tick();
        drive(1'b1, 32'h00500093);
        chk("x0_in_ready", 64'(in_ready), 64'd1);
        tick();
        drive(1'b0, 32'h0);
        chk("x0_next_rd", 64'(out_rd), 64'd1);
        chk("x0_stall_cnt", 64'(stall_count), 64'd1);
        tick();

        // ---------------- back-to-back loads: lw x2,0(x1); lw x4,0(x2) ----------------
        drive(1'b1, 32'h0000A103);
        tick();
        drive(1'b1, 32'h00012203);
        chk("ll_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("ll_bubble",    64'(out_valid), 64'd0);
        chk("ll_stall_cnt", 64'(stall_count), 64'd2);
        tick();
        drive(1'b0, 32'h0);
        chk("ll_second_rd", 64'(out_rd), 64'd4);
        chk("ll_second_mr", 64'(out_MemRead), 64'd1);
        tick();

        // ---------------- flush during hazard ----------------
        drive(1'b1, 32'h0000A103);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'h001101B3);
        chk("fl_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0);
        chk("fl_valid",     64'(out_valid), 64'd0);
        chk("fl_stall_cnt", 64'(stall_count), 64'd2);

        // ---------------- reset mid-stall ----------------
        drive(1'b1, 32'h0000A103);
        tick();
        drive(1'b1, 32'h001101B3);
        tick();
        chk("rs_stall_before", 64'(stall_count), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_valid",     64'(out_valid), 64'd0);
        chk("rs_stall_cnt", 64'(stall_count), 64'd0);
        drive(1'b0, 32'h0);
        tick();
        rst_n = 1'b1;
        #1;

        // ---------------- RV64: slli x1,x1,63 ----------------
        in_valid64 = 1'b1;
        in_instr64 = 32'h03F09093;
        tick();
        in_valid64 = 1'b0;
        chk("x64_valid", 64'(out_valid64), 64'd1);
        chk("x64_shamt", 64'(out_shamt64), 64'd63);
        chk("x64_imm",   out_imm64, 64'd63);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
